// File: rtl/rc_multicast_gen_pkg.sv
// Shared constants and helpers for the multicast route-computation stage.
// Directions are one-hot: bit0 L, bit1 N, bit2 E, bit3 S, bit4 W.
package rc_mc_pkg;

  localparam logic [4:0] DIR_L = 5'b00001;
  localparam logic [4:0] DIR_N = 5'b00010;
  localparam logic [4:0] DIR_E = 5'b00100;
  localparam logic [4:0] DIR_S = 5'b01000;
  localparam logic [4:0] DIR_W = 5'b10000;

  function automatic int nodes_of(input int mesh_x, input int mesh_y);
    return mesh_x * mesh_y;
  endfunction

  function automatic int payload_width(input int datasize, input int nodes);
    return datasize - nodes;
  endfunction

  // XY dimension order: resolve X first, then Y, otherwise deliver locally.
  function automatic logic [4:0] node_dir(input int node, input int router_id, input int mesh_x);
    int x;
    int y;
    int dx;
    int dy;
    x  = router_id % mesh_x;
    y  = router_id / mesh_x;
    dx = node % mesh_x;
    dy = node / mesh_x;
    if (dx > x) return DIR_E;
    if (dx < x) return DIR_W;
    if (dy < y) return DIR_N;
    if (dy > y) return DIR_S;
    return DIR_L;
  endfunction

endpackage

// File: rtl/rc_multicast_gen_if.sv
// Flat per-channel buses between input buffers, the RC stage and the switch allocator.
interface rc_multicast_gen_if #(
  parameter int NUM_IN     = 2,
  parameter int DATASIZE   = 30,
  parameter int MAX_FANOUT = 3
);
  logic [NUM_IN*DATASIZE-1:0]            data_in;
  logic [NUM_IN-1:0]                     valid_in;
  logic [NUM_IN-1:0]                     in_ready;
  logic [NUM_IN-1:0]                     rc_ready;
  logic [NUM_IN*MAX_FANOUT*DATASIZE-1:0] data_out;
  logic [NUM_IN*MAX_FANOUT*5-1:0]        direction_out;
  logic [NUM_IN*MAX_FANOUT-1:0]          valid_out;

  modport master (
    output data_in, valid_in, rc_ready,
    input  in_ready, data_out, direction_out, valid_out
  );

  modport slave (
    input  data_in, valid_in, rc_ready,
    output in_ready, data_out, direction_out, valid_out
  );
endinterface

// File: rtl/rc_multicast_gen_chan.sv
// One RC channel: flit FIFO, destination-mask decode, beat FSM and branch selection.
module rc_multicast_chan
  import rc_mc_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int WIDTH      = 2,
  parameter int DATASIZE   = 30,
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 4,
  parameter int MAX_FANOUT = 3,
  parameter int router_ID  = 6
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [DATASIZE-1:0]            data_in,
  input  logic                           valid_in,
  output logic                           in_ready,
  input  logic                           rc_ready,
  output logic [MAX_FANOUT*DATASIZE-1:0] data_out,
  output logic [MAX_FANOUT*5-1:0]        direction_out,
  output logic [MAX_FANOUT-1:0]          valid_out
);
  localparam int NODES = nodes_of(MESH_X, MESH_Y);
  localparam int PW    = payload_width(DATASIZE, NODES);
  localparam logic [WIDTH:0] FULL_CNT = (WIDTH+1)'(DEPTH);
  localparam logic [2:0]     FAN      = 3'(MAX_FANOUT);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t                state_reg, state_next;
  logic [4:0]            pending_reg, pending_next;
  logic [WIDTH-1:0]      wr_ptr_reg, rd_ptr_reg;
  logic [WIDTH:0]        count_reg;
  logic [DATASIZE-1:0]   mem [DEPTH];
  logic                  push, pop, full, empty;
  logic [DATASIZE-1:0]   head;
  logic [NODES-1:0]      head_mask;
  logic [PW-1:0]         head_payload;
  logic [4:0]            node_dir_vec [NODES];
  logic [NODES-1:0]      dir_nodes [5];
  logic [4:0]            head_dirs;
  logic [4:0]            shown;
  logic [2:0]            rank [5];

  assign full         = (count_reg == FULL_CNT);
  assign empty        = (count_reg == '0);
  assign in_ready     = !full;
  assign push         = valid_in && !full;
  assign head         = mem[rd_ptr_reg];
  assign head_mask    = head[DATASIZE-1 -: NODES];
  assign head_payload = head[PW-1:0];

  for (genvar gi = 0; gi < NODES; gi++) begin : g_node
    assign node_dir_vec[gi] = node_dir(gi, router_ID, MESH_X);
  end

  always_comb begin
    head_dirs = '0;
    for (int b = 0; b < 5; b++) begin
      dir_nodes[b] = '0;
      for (int n = 0; n < NODES; n++) dir_nodes[b][n] = node_dir_vec[n][b];
      head_dirs[b] = |(head_mask & dir_nodes[b]);
    end
  end

  // rank[b] = number of pending directions below b, i.e. the branch slot b lands on.
  always_comb begin
    rank[0] = 3'd0;
    for (int b = 1; b < 5; b++) rank[b] = rank[b-1] + {2'b00, pending_reg[b-1]};
    shown = '0;
    for (int b = 0; b < 5; b++) shown[b] = (state_reg == EMIT) && pending_reg[b] && (rank[b] < FAN);
  end

  for (genvar gi = 0; gi < MAX_FANOUT; gi++) begin : g_branch
    logic                br_valid;
    logic [4:0]          br_dir;
    logic [DATASIZE-1:0] br_data;
    always_comb begin
      br_valid = 1'b0;
      br_dir   = '0;
      br_data  = '0;
      for (int b = 0; b < 5; b++) begin
        if (shown[b] && rank[b] == 3'(gi)) begin
          br_valid = 1'b1;
          br_dir   = 5'b00001 << b;
          br_data  = {head_mask & dir_nodes[b], head_payload};
        end
      end
    end
    assign valid_out[gi]                         = br_valid;
    assign direction_out[gi*5 +: 5]              = br_dir;
    assign data_out[gi*DATASIZE +: DATASIZE]     = br_data;
  end

  always_comb begin
    state_next   = state_reg;
    pending_next = pending_reg;
    pop          = 1'b0;
    case (state_reg)
      IDLE: begin
        if (!empty) begin
          if (head_dirs == '0) begin
            pop = 1'b1;
          end else begin
            pending_next = head_dirs;
            state_next   = EMIT;
          end
        end
      end
      EMIT: begin
        if (rc_ready) begin
          pending_next = pending_reg & ~shown;
          if (pending_next == '0) begin
            pop        = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      pending_reg <= '0;
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      count_reg   <= '0;
    end else begin
      state_reg   <= state_next;
      pending_reg <= pending_next;
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (push && !pop)      count_reg <= count_reg + 1'b1;
      else if (pop && !push) count_reg <= count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= data_in;
  end

endmodule

// File: rtl/rc_multicast_gen.sv
// Multicast RC stage: NUM_IN independent channels sliced out of the flat interface buses.
module rc_multicast_gen
  import rc_mc_pkg::*;
#(
  parameter int NUM_IN     = 2,
  parameter int DEPTH      = 4,
  parameter int WIDTH      = 2,
  parameter int DATASIZE   = 30,
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 4,
  parameter int MAX_FANOUT = 3,
  parameter int router_ID  = 6
) (
  input logic               rc_clk,
  input logic               rst_n,
  rc_multicast_gen_if.slave bus
);
  localparam int BW = MAX_FANOUT * DATASIZE;
  localparam int DW = MAX_FANOUT * 5;

  for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
    rc_multicast_chan #(
      .DEPTH     (DEPTH),
      .WIDTH     (WIDTH),
      .DATASIZE  (DATASIZE),
      .MESH_X    (MESH_X),
      .MESH_Y    (MESH_Y),
      .MAX_FANOUT(MAX_FANOUT),
      .router_ID (router_ID)
    ) u_chan (
      .clk          (rc_clk),
      .rst_n        (rst_n),
      .data_in      (bus.data_in[gi*DATASIZE +: DATASIZE]),
      .valid_in     (bus.valid_in[gi]),
      .in_ready     (bus.in_ready[gi]),
      .rc_ready     (bus.rc_ready[gi]),
      .data_out     (bus.data_out[gi*BW +: BW]),
      .direction_out(bus.direction_out[gi*DW +: DW]),
      .valid_out    (bus.valid_out[gi*MAX_FANOUT +: MAX_FANOUT])
    );
  end

endmodule

// File: doc/rc_multicast_gen.md
# rc_multicast_gen

Parametrised multicast route-computation stage for the mesh router. It replaces the fixed two-input, three-branch RC with NUM_IN independent input channels. Each channel has a DEPTH-entry flit FIFO, decodes a destination bitmask into XY dimension-order output directions, and splits the mask per direction. When a packet needs more directions than MAX_FANOUT branches, it is emitted over several beats. The block sits between the input buffers and the switch allocator.

## Interface
- NUM_IN, 2, number of input channels
- DEPTH, 4, FIFO entries per channel
- WIDTH, 2, log2(DEPTH) pointer width
- DATASIZE, 30, flit width: [DATASIZE-1 -: NODES] destination mask, remaining low bits payload
- MESH_X, 4, mesh columns; MESH_Y, 4, mesh rows; NODES = MESH_X*MESH_Y
- MAX_FANOUT, 3, output branches per channel (1..5)
- router_ID, 6, own node; x = router_ID % MESH_X, y = router_ID / MESH_X
- rc_clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- data_in  in  NUM_IN*DATASIZE  flit per channel
- valid_in  in  NUM_IN  flit present
- in_ready  out  NUM_IN  FIFO not full
- rc_ready  in  NUM_IN  downstream accepts current beat of channel
- data_out  out  NUM_IN*MAX_FANOUT*DATASIZE  branch flits
- direction_out  out  NUM_IN*MAX_FANOUT*5  one-hot: bit0 L, bit1 N, bit2 E, bit3 S, bit4 W
- valid_out  out  NUM_IN*MAX_FANOUT  branch valid

## Operation
- Channels are fully independent; everything below is per channel.
- FIFO write when valid_in && in_ready. in_ready = !full, with no bypass. A write while full is ignored.
- Direction of destination d, with coordinates (dx,dy):
  - dx>x → E; dx<x → W.
  - Otherwise dy<y → N; dy>y → S.
  - Otherwise L.
- The direction set of a flit is the OR over all set mask bits.
- FSM states:
  - IDLE: if the FIFO is non-empty, load pending[4:0] = direction set of head and go to EMIT.
  - IDLE, zero-mask head: pop it, stay in IDLE, produce no output.
  - EMIT: branches 0..MAX_FANOUT-1 show the lowest-numbered set bits of pending, in ascending bit order. Unused branches have valid_out=0, direction_out=0, data_out=0.
- Branch data_out: the head mask ANDed with the destinations of that branch's direction; payload unchanged.
- EMIT, rc_ready=1: clear the shown bits from pending. If pending becomes zero, pop the head and go to IDLE; otherwise stay in EMIT.
- EMIT, rc_ready=0: all outputs hold unchanged.

## Timing
- Reset (asynchronous): FIFO empty, state IDLE, pending=0, all data_out/direction_out/valid_out = 0, in_ready = all ones.
- Latency: a flit written at edge E0 is loaded at E1; valid_out is high after E1. Minimum 2 cycles per single-beat packet. A packet needing k directions needs ceil(k/MAX_FANOUT) accepted beats.
- Simultaneous pop and write in the same edge are both performed; the count is unchanged. in_ready rises the cycle after a pop from full.
- Pointers wrap modulo DEPTH. A WIDTH+1-bit count distinguishes full from empty.
- rst_n asserted mid-packet discards the FIFO contents and pending. Outputs go to zero immediately.

## Structure
- Package rc_mc_pkg holds:
  - direction one-hot constants DIR_L/N/E/S/W;
  - the NODES and payload-width functions;
  - a function mapping (node, router_ID, MESH_X) → direction.
- Sub-module rc_multicast_chan implements one channel: FIFO, decode, FSM and branch selection. The top level instantiates NUM_IN of them with a generate loop and slices the flat ports.

## Test plan
- Defaults. Mask bit 7 only, payload 0x0AB → one beat: branch0 direction=00100 (E), mask 0x0080, payload 0x0AB. Branches 1–2 have valid_out=0. The FIFO pops when rc_ready=1.
- Mask bits {2,5,6,7,10} → beat 1: L, N, E with masks 0x0040, 0x0004, 0x0080. Beat 2: S, W with masks 0x0400, 0x0020. The pop happens only after the second accepted beat.
- Hold rc_ready=0 and write 5 flits → in_ready=0 after the 4th write; the 5th flit is dropped. Branch outputs stay constant until rc_ready rises.
- Zero-mask flit followed by a flit with mask bit 6 → no valid_out for the first flit; the second flit appears as L.
- Channel 0 stalled while channel 1 receives mask bit 2 with rc_ready=1 → channel 1 emits N two cycles after its write. Channel 0 outputs are unaffected.
- Assert rst_n low during beat 1 of a two-beat packet → all valid_out=0 and in_ready=all ones immediately. No stale beat appears after release.
